work_fetcher: RTL and testbench

Fetches one 80-byte Bitcoin block header (a work unit) from host memory through the PCIe read master and presents it whole to the hashing core. Sits between the read-master control/user interfaces and the nonce-search core. Issues one read burst per request, drains the master FIFO, assembles the header, then holds it until the core acknowledges. Debug count outputs feed the HEX/LED status path.

---
 rtl/miner_pkg.sv | 20 ++
 rtl/work_fetcher.sv | 146 ++++++++++++++
 tb/tb_work_fetcher.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared types and helpers for the miner datapath: work-fetch FSM states,
// work-unit geometry and the word byte-reversal used when capturing headers.
package miner_pkg;

  typedef enum logic [2:0] {
    WF_IDLE,
    WF_GO,
    WF_READ,
    WF_HOLD,
    WF_ERROR
  } work_fetch_state_t;

  localparam int WORK_WORDS_DEFAULT = 20;
  localparam int WORK_BYTES         = 80;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/work_fetcher.sv
// Fetches one 80-byte block header through the read master, assembles it and
// holds it for the hashing core until acknowledged.
module work_fetcher
  import miner_pkg::*;
#(
  parameter int ADDRESSWIDTH   = 28,
  parameter int DATAWIDTH      = 32,
  parameter int WORK_WORDS     = WORK_WORDS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit BYTE_SWAP      = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDRESSWIDTH-1:0]    base_addr,
  output logic                       read_control_fixed_location,
  output logic [ADDRESSWIDTH-1:0]    read_control_read_base,
  output logic [ADDRESSWIDTH-1:0]    read_control_read_length,
  output logic                       read_control_go,
  input  logic                       read_control_done,
  output logic                       read_user_read_buffer,
  input  logic [DATAWIDTH-1:0]       read_user_buffer_output_data,
  input  logic                       read_user_data_available,
  output logic [WORK_WORDS*32-1:0]   work_header,
  output logic                       work_valid,
  input  logic                       work_ack,
  output logic                       busy,
  output logic                       fetch_error,
  output logic [7:0]                 words_received
);

  work_fetch_state_t       state;
  logic [ADDRESSWIDTH-1:0] read_base;
  logic [31:0]             words [WORK_WORDS];
  logic [7:0]              wr_cnt;
  logic [7:0]              wr_next;
  logic [31:0]             tmo_cnt;
  logic                    done_seen;
  logic                    pop;
  logic                    complete;
  logic                    expired;
  logic [31:0]             capture;
  logic                    unused_addr_bits;

  // The master always reads word-aligned, so the low address bits are dropped.
  assign unused_addr_bits            = ^base_addr[1:0];
  assign read_control_fixed_location = 1'b0;
  assign read_control_read_base      = read_base;
  assign read_control_read_length    = ADDRESSWIDTH'(WORK_WORDS * 4);
  assign words_received              = wr_cnt;

  assign pop      = (state == WF_READ) && read_user_data_available &&
                    (wr_cnt < 8'(WORK_WORDS));
  assign read_user_read_buffer = pop;
  assign wr_next  = wr_cnt + 8'(pop);
  assign capture  = BYTE_SWAP ? byte_swap32(read_user_buffer_output_data[31:0])
                              : read_user_buffer_output_data[31:0];
  // Completion looks at the post-pop count so work_valid follows the last pop by one cycle.
  assign complete = (wr_next == 8'(WORK_WORDS)) && (done_seen || read_control_done);
  assign expired  = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    work_header = '0;
    for (int i = 0; i < WORK_WORDS; i++) begin
      work_header[i*32 +: 32] = words[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= WF_IDLE;
      read_base       <= '0;
      wr_cnt          <= '0;
      tmo_cnt         <= '0;
      done_seen       <= 1'b0;
      fetch_error     <= 1'b0;
      read_control_go <= 1'b0;
      work_valid      <= 1'b0;
      busy            <= 1'b0;
      for (int i = 0; i < WORK_WORDS; i++) begin
        words[i] <= '0;
      end
    end else begin
      read_control_go <= 1'b0;
      case (state)
        WF_IDLE: begin
          if (start) begin
            read_base       <= {base_addr[ADDRESSWIDTH-1:2], 2'b00};
            wr_cnt          <= '0;
            tmo_cnt         <= '0;
            done_seen       <= 1'b0;
            fetch_error     <= 1'b0;
            read_control_go <= 1'b1;
            busy            <= 1'b1;
            state           <= WF_GO;
          end
        end
        WF_GO: begin
          done_seen <= done_seen | read_control_done;
          if (expired) begin
            fetch_error <= 1'b1;
            state       <= WF_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
            state   <= WF_READ;
          end
        end
        WF_READ: begin
          done_seen <= done_seen | read_control_done;
          if (pop) begin
            for (int i = 0; i < WORK_WORDS; i++) begin
              if (wr_cnt == 8'(i)) words[i] <= capture;
            end
            wr_cnt <= wr_next;
          end
          // A fetch finishing on the expiry cycle is still presented.
          if (complete) begin
            work_valid <= 1'b1;
            state      <= WF_HOLD;
          end else if (expired) begin
            fetch_error <= 1'b1;
            state       <= WF_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        WF_HOLD: begin
          if (work_ack) begin
            work_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= WF_IDLE;
          end
        end
        WF_ERROR: begin
          busy  <= 1'b0;
          state <= WF_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= WF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_work_fetcher.sv
// Directed bench for work_fetcher: instance A uses default parameters, instance B
// uses a short timeout with byte swapping enabled.
module tb_work_fetcher;

  localparam int AW = 28;
  localparam int WW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic          rst_a, start_a, done_a, avail_a, ack_a;
  logic [AW-1:0] base_a;
  logic [31:0]   data_a;
  logic          fixed_a, go_a, rb_a, valid_a, busy_a, err_a;
  logic [AW-1:0] rbase_a, rlen_a;
  logic [WW*32-1:0] hdr_a;
  logic [7:0]    wrc_a;

  // Instance B signals
  logic          rst_b, start_b, done_b, avail_b, ack_b;
  logic [AW-1:0] base_b;
  logic [31:0]   data_b;
  logic          fixed_b, go_b, rb_b, valid_b, busy_b, err_b;
  logic [AW-1:0] rbase_b, rlen_b;
  logic [WW*32-1:0] hdr_b;
  logic [7:0]    wrc_b;

  work_fetcher #(.ADDRESSWIDTH(AW), .DATAWIDTH(32), .WORK_WORDS(WW),
                 .TIMEOUT_CYCLES(1_000_000), .BYTE_SWAP(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .base_addr(base_a),
    .read_control_fixed_location(fixed_a), .read_control_read_base(rbase_a),
    .read_control_read_length(rlen_a), .read_control_go(go_a),
    .read_control_done(done_a), .read_user_read_buffer(rb_a),
    .read_user_buffer_output_data(data_a), .read_user_data_available(avail_a),
    .work_header(hdr_a), .work_valid(valid_a), .work_ack(ack_a),
    .busy(busy_a), .fetch_error(err_a), .words_received(wrc_a));

  work_fetcher #(.ADDRESSWIDTH(AW), .DATAWIDTH(32), .WORK_WORDS(WW),
                 .TIMEOUT_CYCLES(50), .BYTE_SWAP(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .base_addr(base_b),
    .read_control_fixed_location(fixed_b), .read_control_read_base(rbase_b),
    .read_control_read_length(rlen_b), .read_control_go(go_b),
    .read_control_done(done_b), .read_user_read_buffer(rb_b),
    .read_user_buffer_output_data(data_b), .read_user_data_available(avail_b),
    .work_header(hdr_b), .work_valid(valid_b), .work_ack(ack_b),
    .busy(busy_b), .fetch_error(err_b), .words_received(wrc_b));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Read-master FIFO models (show-ahead)
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  bit en_a, en_b, tgl_a;
  int pops_a, pops_b;
  logic [31:0] exp_a [WW];
  logic [31:0] exp_b [WW];

  task automatic refresh();
    avail_a = en_a && (q_a.size() > 0);
    data_a  = (q_a.size() > 0) ? q_a[0] : 32'h0;
    avail_b = en_b && (q_b.size() > 0);
    data_b  = (q_b.size() > 0) ? q_b[0] : 32'h0;
  endtask

  task automatic tick();
    bit p_a, p_b;
    refresh();
    #1;
    p_a = rb_a;
    p_b = rb_b;
    @(posedge clk);
    @(negedge clk);
    if (p_a && q_a.size() > 0) begin q_a.delete(0); pops_a++; end
    if (p_b && q_b.size() > 0) begin q_b.delete(0); pops_b++; end
    if (tgl_a) en_a = !en_a;
    refresh();
  endtask

  // Ticks until instance A presents work, pulsing done once pops reach done_at.
  task automatic run_a(input int done_at, output bit ok);
    bit sent = 0;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (!sent && pops_a >= done_at) begin done_a = 1'b1; sent = 1; end
      tick();
      done_a = 1'b0;
      ok = valid_a;
    end
  endtask

  task automatic run_b(input int done_at, output bit ok);
    bit sent = 0;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (!sent && pops_b >= done_at) begin done_b = 1'b1; sent = 1; end
      tick();
      done_b = 1'b0;
      ok = valid_b;
    end
  endtask

  task automatic start_a_fetch(input logic [AW-1:0] addr);
    base_a = addr; start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({busy_a, valid_a, go_a, err_a, rb_a, fixed_a} !== 6'b0) $display("FAIL reset_ctrl_a got %b want 000000", {busy_a, valid_a, go_a, err_a, rb_a, fixed_a});
    else pass_cnt++;
    total_cnt++;
    if (wrc_a !== 8'd0 || rbase_a !== '0) $display("FAIL reset_counts_a words=%0d base=%h want 0/0", wrc_a, rbase_a);
    else pass_cnt++;
    total_cnt++;
    if (hdr_a !== '0 || hdr_b !== '0) $display("FAIL reset_header got nonzero want 0");
    else pass_cnt++;
    total_cnt++;
    if (rlen_a !== 28'd80 || rlen_b !== 28'd80) $display("FAIL reset_length got %0d/%0d want 80", rlen_a, rlen_b);
    else pass_cnt++;
    total_cnt++;
    if ({busy_b, valid_b, go_b, err_b} !== 4'b0) $display("FAIL reset_ctrl_b got %b want 0000", {busy_b, valid_b, go_b, err_b});
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    bit ok;
    pops_a = 0; en_a = 1;
    for (int i = 0; i < WW; i++) begin q_a.push_back(32'(i + 1)); exp_a[i] = 32'(i + 1); end
    start_a_fetch(28'h000_1003);
    total_cnt++;
    if (go_a !== 1'b1 || busy_a !== 1'b1) $display("FAIL nom_go got go=%b busy=%b want 1/1", go_a, busy_a);
    else pass_cnt++;
    total_cnt++;
    if (rbase_a !== 28'h000_1000) $display("FAIL nom_base got %h want 0001000", rbase_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (go_a !== 1'b0) $display("FAIL nom_go_once got %b want 0", go_a);
    else pass_cnt++;
    run_a(WW, ok);
    total_cnt++;
    if (!ok) $display("FAIL nom_valid_timeout got valid=%b want 1", valid_a);
    else pass_cnt++;
    total_cnt++;
    if (hdr_a[31:0] !== 32'h1 || hdr_a[19*32 +: 32] !== 32'h14) $display("FAIL nom_words got w0=%h w19=%h want 1/14", hdr_a[31:0], hdr_a[19*32 +: 32]);
    else pass_cnt++;
    for (int i = 0; i < WW; i++) begin
      total_cnt++;
      if (hdr_a[i*32 +: 32] !== exp_a[i]) $display("FAIL nom_word%0d got %h want %h", i, hdr_a[i*32 +: 32], exp_a[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (wrc_a !== 8'd20 || pops_a != 20) $display("FAIL nom_count got words=%0d pops=%0d want 20/20", wrc_a, pops_a);
    else pass_cnt++;
    ack_a = 1'b1; tick(); ack_a = 1'b0;
    total_cnt++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL nom_ack got valid=%b busy=%b want 0/0", valid_a, busy_a);
    else pass_cnt++;
  endtask

  task automatic test_done_early();
    bit ok;
    pops_a = 0; en_a = 1;
    for (int i = 0; i < 5; i++) q_a.push_back(32'hA0 + 32'(i));
    start_a_fetch(28'h000_2000);
    for (int n = 0; n < 40 && pops_a < 5; n++) tick();
    done_a = 1'b1; tick(); done_a = 1'b0;
    repeat (10) tick();
    total_cnt++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0 || wrc_a !== 8'd5) $display("FAIL early_wait got busy=%b valid=%b words=%0d want 1/0/5", busy_a, valid_a, wrc_a);
    else pass_cnt++;
    for (int i = 0; i < 18; i++) q_a.push_back(32'hB0 + 32'(i));
    run_a(0, ok);
    total_cnt++;
    if (!ok) $display("FAIL early_valid_timeout got valid=%b want 1", valid_a);
    else pass_cnt++;
    total_cnt++;
    if (pops_a != 20 || q_a.size() != 3 || wrc_a !== 8'd20) $display("FAIL early_no_extra_pop got pops=%0d left=%0d words=%0d want 20/3/20", pops_a, q_a.size(), wrc_a);
    else pass_cnt++;
    total_cnt++;
    if (hdr_a[4*32 +: 32] !== 32'hA4 || hdr_a[5*32 +: 32] !== 32'hB0 || hdr_a[19*32 +: 32] !== 32'hBE) $display("FAIL early_words got w4=%h w5=%h w19=%h want a4/b0/be", hdr_a[4*32 +: 32], hdr_a[5*32 +: 32], hdr_a[19*32 +: 32]);
    else pass_cnt++;
    q_a.delete();
    ack_a = 1'b1; tick(); ack_a = 1'b0;
  endtask

  task automatic test_back_pressure();
    bit ok;
    int bad;
    pops_a = 0; en_a = 1; tgl_a = 1;
    for (int i = 0; i < WW; i++) begin q_a.push_back(32'h100 + 32'(i)); exp_a[i] = 32'h100 + 32'(i); end
    start_a_fetch(28'h000_3000);
    run_a(10, ok);
    tgl_a = 0;
    total_cnt++;
    if (!ok) $display("FAIL bp_valid_timeout got valid=%b want 1", valid_a);
    else pass_cnt++;
    for (int i = 0; i < WW; i++) begin
      total_cnt++;
      if (hdr_a[i*32 +: 32] !== exp_a[i]) $display("FAIL bp_word%0d got %h want %h", i, hdr_a[i*32 +: 32], exp_a[i]);
      else pass_cnt++;
    end
    bad = 0;
    base_a = 28'h000_5000;
    for (int n = 0; n < 100; n++) begin
      start_a = (n % 7 == 3);
      tick();
      for (int i = 0; i < WW; i++) if (hdr_a[i*32 +: 32] !== exp_a[i]) bad++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || go_a !== 1'b0) bad++;
    end
    start_a = 1'b0;
    total_cnt++;
    if (bad != 0) $display("FAIL bp_hold_stable got %0d bad cycles want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (rbase_a !== 28'h000_3000) $display("FAIL bp_start_ignored got base=%h want 0003000", rbase_a);
    else pass_cnt++;
    ack_a = 1'b1; start_a = 1'b1; tick(); ack_a = 1'b0; start_a = 1'b0;
    total_cnt++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || go_a !== 1'b0) $display("FAIL bp_ack_start got busy=%b valid=%b go=%b want 0/0/0", busy_a, valid_a, go_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy_a !== 1'b0 || go_a !== 1'b0) $display("FAIL bp_idle got busy=%b go=%b want 0/0", busy_a, go_a);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit seen_valid = 0;
    pops_b = 0; en_b = 1;
    for (int i = 0; i < 7; i++) q_b.push_back(32'(i));
    base_b = 28'h000_4000; start_b = 1'b1; tick(); start_b = 1'b0;
    total_cnt++;
    if (go_b !== 1'b1) $display("FAIL tmo_go got %b want 1", go_b);
    else pass_cnt++;
    for (int n = 0; n < 49; n++) begin tick(); if (valid_b) seen_valid = 1; end
    total_cnt++;
    if (err_b !== 1'b0 || busy_b !== 1'b1 || wrc_b !== 8'd7) $display("FAIL tmo_before got err=%b busy=%b words=%0d want 0/1/7", err_b, busy_b, wrc_b);
    else pass_cnt++;
    tick();
    if (valid_b) seen_valid = 1;
    total_cnt++;
    if (err_b !== 1'b1 || busy_b !== 1'b1) $display("FAIL tmo_error got err=%b busy=%b want 1/1", err_b, busy_b);
    else pass_cnt++;
    tick();
    if (valid_b) seen_valid = 1;
    total_cnt++;
    if (err_b !== 1'b1 || busy_b !== 1'b0 || seen_valid) $display("FAIL tmo_sticky got err=%b busy=%b sawvalid=%b want 1/0/0", err_b, busy_b, seen_valid);
    else pass_cnt++;
  endtask

  task automatic test_byte_swap();
    bit ok;
    pops_b = 0; en_b = 1;
    q_b.push_back(32'h1122_3344);
    for (int i = 1; i < WW; i++) q_b.push_back(32'(i + 1));
    base_b = 28'h000_6000; start_b = 1'b1; tick(); start_b = 1'b0;
    total_cnt++;
    if (err_b !== 1'b0 || go_b !== 1'b1) $display("FAIL swap_err_clear got err=%b go=%b want 0/1", err_b, go_b);
    else pass_cnt++;
    run_b(WW, ok);
    total_cnt++;
    if (!ok) $display("FAIL swap_valid_timeout got valid=%b want 1", valid_b);
    else pass_cnt++;
    total_cnt++;
    if (hdr_b[31:0] !== 32'h4433_2211 || hdr_b[63:32] !== 32'h0200_0000) $display("FAIL swap_words got w0=%h w1=%h want 44332211/02000000", hdr_b[31:0], hdr_b[63:32]);
    else pass_cnt++;
    ack_b = 1'b1; tick(); ack_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    pops_a = 0; en_a = 1;
    for (int i = 0; i < WW; i++) begin q_a.push_back(32'hC00 + 32'(i)); exp_a[i] = 32'hC00 + 32'(i); end
    start_a_fetch(28'h000_7004);
    for (int n = 0; n < 60 && pops_a < 10; n++) tick();
    #2 rst_a = 1'b1;
    #1;
    total_cnt++;
    if ({busy_a, valid_a, go_a, err_a} !== 4'b0 || wrc_a !== 8'd0 || rbase_a !== '0 || hdr_a !== '0) $display("FAIL rstmid_async got busy=%b valid=%b words=%0d base=%h want 0/0/0/0", busy_a, valid_a, wrc_a, rbase_a);
    else pass_cnt++;
    q_a.delete();
    tick();
    rst_a = 1'b0;
    pops_a = 0;
    for (int i = 0; i < WW; i++) begin q_a.push_back(32'hD00 + 32'(i)); exp_a[i] = 32'hD00 + 32'(i); end
    start_a_fetch(28'h000_8000);
    run_a(3, ok);
    total_cnt++;
    if (!ok) $display("FAIL rstmid_refetch_timeout got valid=%b want 1", valid_a);
    else pass_cnt++;
    total_cnt++;
    if (hdr_a[31:0] !== 32'hD00 || hdr_a[19*32 +: 32] !== 32'hD13 || wrc_a !== 8'd20) $display("FAIL rstmid_words got w0=%h w19=%h words=%0d want d00/d13/20", hdr_a[31:0], hdr_a[19*32 +: 32], wrc_a);
    else pass_cnt++;
    ack_a = 1'b1; tick(); ack_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 0; done_a = 0; ack_a = 0; base_a = '0;
    start_b = 0; done_b = 0; ack_b = 0; base_b = '0;
    en_a = 0; en_b = 0; tgl_a = 0; pops_a = 0; pops_b = 0;
    refresh();
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    test_reset();
    test_nominal();
    test_done_early();
    test_back_pressure();
    test_timeout();
    test_byte_swap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
